shift_ctrl: RTL and testbench

- Control stage that sits directly upstream of the LED shift register.
- Turns raw board switches and a push-button into a one-cycle shift-enable strobe at a selectable rate, plus a direction level.
- Provides input synchronisation, button debounce, direction toggling, and a 4-rate prescaler with run/pause.
- o_enable and o_shift_dir connect straight to the shift register's i_enable and i_shift_dir on the same clock.

---
 rtl/shift_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_shift_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_ctrl
//  Brief    : Control stage ahead of the LED shift register. Synchronises the
//             board switches and direction button, debounces the button,
//             toggles the shift direction on each accepted press, and
//             produces a one-cycle shift strobe at one of four rates with
//             run/pause.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_ctrl #(
    parameter int          NB_COUNTER = 32,
    parameter int unsigned LIMIT_0    = 2**20,
    parameter int unsigned LIMIT_1    = 2**22,
    parameter int unsigned LIMIT_2    = 2**24,
    parameter int unsigned LIMIT_3    = 2**26,
    parameter int unsigned DB_CYCLES  = 2**16
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [2:0] i_sw,
    input  logic       i_btn_dir,
    output logic       o_enable,
    output logic       o_shift_dir,
    output logic       o_run
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Terminal counts are pre-computed at NB_COUNTER width so every compare
    // in the prescaler is a plain unsigned equality.
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_0 = NB_COUNTER'(LIMIT_0 - 1);
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_1 = NB_COUNTER'(LIMIT_1 - 1);
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_2 = NB_COUNTER'(LIMIT_2 - 1);
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_3 = NB_COUNTER'(LIMIT_3 - 1);

    // The stability counter never exceeds DB_CYCLES-1.
    localparam int                NB_DB  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [NB_DB-1:0]  DB_TOP = NB_DB'(DB_CYCLES - 1);

    // Prescaler run/pause state. The state register doubles as the second
    // synchroniser stage of the run switch, so run_s is simply the state.
    localparam logic [0:0] ST_PAUSED  = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    // Synchronisers
    logic [2:0]            sw_meta;
    logic [1:0]            sel_s;
    logic                  btn_meta;
    logic                  btn_s;

    // Run/pause FSM
    logic [0:0]            state;
    logic [0:0]            next_state;
    logic                  run_s;

    // Prescaler
    logic [1:0]            sel_q;
    logic [NB_COUNTER-1:0] count;
    logic [NB_COUNTER-1:0] count_next;
    logic [NB_COUNTER-1:0] limit_m1;
    logic                  enable_next;
    logic                  sel_change;

    // Debounce and direction
    logic                  btn_db;
    logic [NB_DB-1:0]      db_count;
    logic [NB_DB-1:0]      db_count_next;
    logic                  db_accept;
    logic                  shift_dir;
    logic                  enable;

    // ------------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous speed select and button.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sw_meta  <= 3'b000;
            sel_s    <= 2'b00;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            sw_meta  <= i_sw;
            sel_s    <= sw_meta[2:1];
            btn_meta <= i_btn_dir;
            btn_s    <= btn_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Run/pause FSM
    // ------------------------------------------------------------------------
    // State register: second stage of the run-switch synchroniser.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_PAUSED;
        end else begin
            state <= next_state;
        end
    end

    // Next state follows the first synchroniser stage of the run switch.
    always_comb begin
        next_state = ST_PAUSED;
        if (sw_meta[0]) begin
            next_state = ST_RUNNING;
        end
    end

    assign run_s = (state == ST_RUNNING);

    // Terminal-count select for the currently latched speed.
    always_comb begin
        limit_m1 = LIMIT_M1_0;
        case (sel_q)
            2'd0:    limit_m1 = LIMIT_M1_0;
            2'd1:    limit_m1 = LIMIT_M1_1;
            2'd2:    limit_m1 = LIMIT_M1_2;
            default: limit_m1 = LIMIT_M1_3;
        endcase
    end

    // Output decode: a speed change restarts the period and overrides any
    // pulse due on the same edge; pause holds the count without clearing it.
    always_comb begin
        sel_change  = (sel_s != sel_q);
        count_next  = count;
        enable_next = 1'b0;
        if (sel_change) begin
            count_next = '0;
        end else if (state == ST_RUNNING) begin
            if (count == limit_m1) begin
                count_next  = '0;
                enable_next = 1'b1;
            end else begin
                count_next = count + NB_COUNTER'(1);
            end
        end
    end

    // Prescaler registers. sel_q always ends up equal to sel_s: it either
    // already matches or it is the speed-change case that loads it.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sel_q  <= 2'b00;
            count  <= '0;
            enable <= 1'b0;
        end else begin
            sel_q  <= sel_s;
            count  <= count_next;
            enable <= enable_next;
        end
    end

    // ------------------------------------------------------------------------
    // Button debounce and direction toggle
    // ------------------------------------------------------------------------
    // A new level is accepted once it has differed from the debounced level
    // on DB_CYCLES consecutive edges; any return to the old level restarts.
    always_comb begin
        db_accept     = 1'b0;
        db_count_next = '0;
        if (btn_s != btn_db) begin
            if (db_count == DB_TOP) begin
                db_accept = 1'b1;
            end else begin
                db_count_next = db_count + NB_DB'(1);
            end
        end
    end

    // Debounced level, stability count, and direction, which flips on the
    // same edge that the debounced level rises (a release never toggles).
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_db    <= 1'b0;
            db_count  <= '0;
            shift_dir <= 1'b1;
        end else begin
            db_count <= db_count_next;
            if (db_accept) begin
                btn_db <= btn_s;
                if (btn_s) begin
                    shift_dir <= ~shift_dir;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from flops)
    // ------------------------------------------------------------------------
    assign o_enable    = enable;
    assign o_shift_dir = shift_dir;
    assign o_run       = run_s;

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_ctrl
//  Brief    : Self-checking bench for shift_ctrl. A behavioural model tracks
//             elapsed cycles per period and consecutive differing button
//             samples; directed scenarios plus randomised switch/button
//             activity are compared against it every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_ctrl;

    localparam int DB = 3;

    logic       clock;
    logic       i_reset;
    logic [2:0] i_sw;
    logic       i_btn_dir;
    logic       o_enable;
    logic       o_shift_dir;
    logic       o_run;

    int n_tests = 0;
    int n_fail  = 0;

    shift_ctrl #(
        .NB_COUNTER (32),
        .LIMIT_0    (4),
        .LIMIT_1    (8),
        .LIMIT_2    (16),
        .LIMIT_3    (1),
        .DB_CYCLES  (DB)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_sw        (i_sw),
        .i_btn_dir   (i_btn_dir),
        .o_enable    (o_enable),
        .o_shift_dir (o_shift_dir),
        .o_run       (o_run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int         limits [4] = '{4, 8, 16, 1};
    logic [2:0] m_sw1, m_sw2;      // switch values seen 1 and 2 edges ago
    logic       m_btn1, m_btn2;
    logic       m_db, m_dir, m_en;
    logic [1:0] m_sel;
    int         m_elapsed;         // cycles run since the period began
    int         m_differ;          // consecutive edges button != accepted level
    logic       prev_dir;
    int         toggles;

    task automatic model_reset();
        m_sw1 = 3'b000; m_sw2 = 3'b000; m_btn1 = 1'b0; m_btn2 = 1'b0;
        m_db = 1'b0; m_dir = 1'b1; m_en = 1'b0; m_sel = 2'b00;
        m_elapsed = 0; m_differ = 0;
    endtask

    task automatic model_step();
        logic       run_now;
        logic [1:0] sel_now;
        logic       btn_now;
        run_now = m_sw2[0];
        sel_now = m_sw2[2:1];
        btn_now = m_btn2;
        if (sel_now != m_sel) begin
            m_sel = sel_now;
            m_elapsed = 0;
            m_en = 1'b0;
        end else if (!run_now) begin
            m_en = 1'b0;
        end else begin
            m_elapsed = m_elapsed + 1;
            m_en = (m_elapsed == limits[m_sel]);
            if (m_en) m_elapsed = 0;
        end
        if (btn_now == m_db) begin
            m_differ = 0;
        end else begin
            m_differ = m_differ + 1;
            if (m_differ == DB) begin
                m_db = btn_now;
                m_differ = 0;
                if (btn_now) m_dir = ~m_dir;
            end
        end
        m_sw2 = m_sw1; m_sw1 = i_sw;
        m_btn2 = m_btn1; m_btn1 = i_btn_dir;
    endtask

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("enable", {31'b0, o_enable},    {31'b0, m_en});
        check("dir",    {31'b0, o_shift_dir}, {31'b0, m_dir});
        check("run",    {31'b0, o_run},       {31'b0, m_sw2[0]});
        if (o_shift_dir !== prev_dir) toggles++;
        prev_dir = o_shift_dir;
    endtask

    // One clock: model follows the active edge, DUT sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        if (i_reset) model_step();
        else         model_reset();
        @(negedge clock);
        compare_outputs();
    endtask

    // Ticks until the selected output (0=enable, 1=run) reads 1; max+1 on timeout.
    task automatic ticks_until(input int which, input int max, output int n);
        n = max + 1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if ((which == 0 && o_enable) || (which == 1 && o_run)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (o_enable) n++;
        end
    endtask

    // Asynchronous reset asserted a little after an active edge.
    task automatic async_reset();
        @(posedge clock);
        if (i_reset) model_step();
        #2 i_reset = 1'b0;
        #1;
        check("rst_enable", {31'b0, o_enable},    32'd0);
        check("rst_dir",    {31'b0, o_shift_dir}, 32'd1);
        check("rst_run",    {31'b0, o_run},       32'd0);
        model_reset();
        @(negedge clock);
        compare_outputs();
        i_reset = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        i_reset   = 1'b0;
        i_sw      = 3'b000;
        i_btn_dir = 1'b0;
        prev_dir  = 1'b1;
        toggles   = 0;
        model_reset();
        repeat (3) tick();
        check("reset_enable", {31'b0, o_enable},    32'd0);
        check("reset_dir",    {31'b0, o_shift_dir}, 32'd1);
        check("reset_run",    {31'b0, o_run},       32'd0);

        // 1: run at speed 0
        i_sw = 3'b001;
        i_reset = 1'b1;
        tick(); tick();
        check("t1_run_latency", {31'b0, o_run}, 32'd1);
        ticks_until(0, 20, n);
        check("t1_first_pulse", n, 32'd4);
        count_pulses(16, n);
        check("t1_pulses_16", n, 32'd4);
        check("t1_dir", {31'b0, o_shift_dir}, 32'd1);

        // 2: speed change lands on the edge a pulse was due, suppressing it
        tick();
        i_sw = 3'b011;
        ticks_until(0, 30, n);
        check("t2_after_change", n, 32'd11);
        count_pulses(16, n);
        check("t2_pulses_16", n, 32'd2);

        // 3: pause two cycles into a speed-2 period, then resume
        i_sw = 3'b101;
        repeat (3) tick();
        i_sw = 3'b100;
        count_pulses(50, n);
        check("t3_paused_pulses", n, 32'd0);
        i_sw = 3'b101;
        ticks_until(1, 10, n);
        ticks_until(0, 40, n);
        check("t3_resume_remaining", n, 32'd14);

        // 4: bouncy press then bouncy release
        toggles = 0;
        foreach (limits[k]) begin
            i_btn_dir = ~k[0];
            tick();
        end
        i_btn_dir = 1'b1;
        repeat (10) tick();
        check("t4_press_toggles", toggles, 32'd1);
        check("t4_press_dir", {31'b0, o_shift_dir}, 32'd0);
        foreach (limits[k]) begin
            i_btn_dir = k[0];
            tick();
        end
        i_btn_dir = 1'b0;
        repeat (10) tick();
        check("t4_release_toggles", toggles, 32'd1);

        // 5: LIMIT=1 gives a continuous strobe while running
        i_sw = 3'b111;
        repeat (6) tick();
        count_pulses(10, n);
        check("t5_continuous", n, 32'd10);
        i_sw = 3'b110;
        repeat (4) tick();
        check("t5_stopped", {31'b0, o_enable}, 32'd0);

        // 6: asynchronous reset mid-period, then restart from zero
        i_sw = 3'b001;
        repeat (7) tick();
        check("t6_pre_dir", {31'b0, o_shift_dir}, 32'd0);
        async_reset();
        ticks_until(1, 10, n);
        check("t6_run_latency", n, 32'd2);
        ticks_until(0, 20, n);
        check("t6_first_pulse", n, 32'd4);

        // Randomised switch and button activity
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 15) == 0) i_sw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)  i_btn_dir = ~i_btn_dir;
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
